// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for a single-port data memory.
// Generates byte strobes, checks alignment and extends load data.
module dmem_arbiter #(
    parameter int Depth = 128,
    parameter int Width = 32,
    parameter int AddrW = $clog2(Depth) + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [AddrW-1:0] m0_addr,
    input  logic [1:0]       m0_size,
    input  logic             m0_unsigned,
    input  logic [Width-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [Width-1:0] m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [AddrW-1:0] m1_addr,
    input  logic [1:0]       m1_size,
    input  logic             m1_unsigned,
    input  logic [Width-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [Width-1:0] m1_rdata,
    output logic             m1_err,
    output logic             mem_we0,
    output logic [AddrW-1:0] mem_wr_addr0,
    output logic [AddrW-1:0] mem_rd_addr0,
    output logic [Width-1:0] mem_wr_din0,
    output logic [3:0]       mem_wr_strb,
    output logic [3:0]       mem_rd_strb,
    input  logic [Width-1:0] mem_rd_dout0
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state, state_next;
    logic               last, last_next;
    logic               grant, grant_id;
    logic               req_id, req_we, req_unsigned;
    logic [AddrW-1:0]   req_addr;
    logic [1:0]         req_size;
    logic [Width-1:0]   req_wdata;
    logic [1:0]         off;
    logic               legal;
    logic [3:0]         strb;
    logic [Width-1:0]   lane, load_data, resp_data;

    // Round-robin pointer only moves when both requesters contend.
    always_comb begin
        state_next = state;
        last_next  = last;
        grant      = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    grant     = 1'b1;
                    grant_id  = ~last;
                    last_next = ~last;
                end else if (m0_req) begin
                    grant = 1'b1;
                end else if (m1_req) begin
                    grant    = 1'b1;
                    grant_id = 1'b1;
                end
                if (grant) state_next = ACCESS;
            end
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign m0_gnt = grant & ~grant_id;
    assign m1_gnt = grant & grant_id;

    assign off = req_addr[1:0];

    always_comb begin
        legal = 1'b0;
        strb  = '0;
        case (req_size)
            2'd0: begin
                legal = 1'b1;
                strb  = 4'b0001 << off;
            end
            2'd1: begin
                legal = (off != 2'd3);
                strb  = 4'b0011 << off;
            end
            2'd2: begin
                legal = (off == 2'd0);
                strb  = '1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) strb = '0;
    end

    always_comb begin
        lane = mem_rd_dout0 >> {off, 3'b000};
        case (req_size)
            2'd0:    load_data = {{(Width-8){lane[7] & ~req_unsigned}}, lane[7:0]};
            2'd1:    load_data = {{(Width-16){lane[15] & ~req_unsigned}}, lane[15:0]};
            default: load_data = lane;
        endcase
        resp_data = (req_we || !legal) ? '0 : load_data;
    end

    assign mem_we0      = (state == ACCESS) && req_we && legal;
    assign mem_wr_addr0 = req_addr;
    assign mem_rd_addr0 = req_addr;
    assign mem_wr_din0  = req_wdata;
    assign mem_wr_strb  = strb;
    assign mem_rd_strb  = 4'b1111;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last         <= 1'b1;
            req_id       <= 1'b0;
            req_we       <= 1'b0;
            req_addr     <= '0;
            req_size     <= '0;
            req_unsigned <= 1'b0;
            req_wdata    <= '0;
            m0_rvalid    <= 1'b0;
            m0_err       <= 1'b0;
            m0_rdata     <= '0;
            m1_rvalid    <= 1'b0;
            m1_err       <= 1'b0;
            m1_rdata     <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            if (grant) begin
                req_id       <= grant_id;
                req_we       <= grant_id ? m1_we       : m0_we;
                req_addr     <= grant_id ? m1_addr     : m0_addr;
                req_size     <= grant_id ? m1_size     : m0_size;
                req_unsigned <= grant_id ? m1_unsigned : m0_unsigned;
                req_wdata    <= grant_id ? m1_wdata    : m0_wdata;
            end
            m0_rvalid <= (state == ACCESS) && !req_id;
            m0_err    <= (state == ACCESS) && !req_id && !legal;
            m1_rvalid <= (state == ACCESS) && req_id;
            m1_err    <= (state == ACCESS) && req_id && !legal;
            if (state == ACCESS && !req_id) m0_rdata <= resp_data;
            if (state == ACCESS && req_id)  m1_rdata <= resp_data;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: requester 0 (core load/store unit) and requester 1 (debug/loader port).
- Each accepted request becomes one memory access. The block generates byte-lane write strobes from size and address.
- It extracts and sign/zero-extends read data itself, so the memory is always read with rd_strb = 4'b1111.
- Sits between the LSU/loader and the data memory; one transaction per two cycles.

Parameters:
- Depth, 128, memory depth in Width-bit words; must match the attached data memory.
- Width, 32, data width; fixed at 32 (strobe logic is 4-lane).
- AddrW, $clog2(Depth)+2, byte-address width (9 at default); matches the memory's address ports.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  requester 0 request; held until m0_gnt
- m0_we  in  1  1 = store, 0 = load
- m0_addr  in  AddrW  byte address
- m0_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- m0_unsigned  in  1  zero-extend loads (lbu/lhu)
- m0_wdata  in  Width  store data, right-aligned (low bits)
- m0_gnt  out  1  request accepted this cycle
- m0_rvalid  out  1  one-cycle response pulse
- m0_rdata  out  Width  extended load data
- m0_err  out  1  misaligned/illegal, valid with m0_rvalid
- m1_*  same set for requester 1
- mem_we0  out  1  memory write enable
- mem_wr_addr0, mem_rd_addr0  out  AddrW  byte address (memory shifts >>2)
- mem_wr_din0  out  Width  write data, right-aligned, unshifted
- mem_wr_strb  out  4  byte-lane write strobe
- mem_rd_strb  out  4  constant 4'b1111
- mem_rd_dout0  in  Width  combinational read data

Behaviour:
- States: IDLE, ACCESS. Reset forces IDLE.
- Reset values: rvalid, err and rdata for both requesters = 0; round-robin pointer last = 1; request register = 0.
- IDLE, arbitration:
  - Any mN_req selects a winner; mN_gnt is asserted combinationally in the same cycle.
  - The request is latched into the request register (id, we, addr, size, unsigned, wdata) and the state goes to ACCESS.
  - Both requesting: winner = requester != last; last updates to the winner.
  - Single requester: that requester wins.
- ACCESS:
  - Memory address ports driven from the latched address.
  - mem_we0 = latched we AND legal.
  - Next edge: return to IDLE; set rvalid/rdata/err for the latched id.
- gnt is never asserted in ACCESS.
- The cycle after ACCESS (the rvalid cycle) is IDLE, so a new grant can be issued in that same cycle.
- Timing: request at cycle T, gnt at T, memory write at the end of T+1, rvalid and rdata at T+2 for exactly one cycle.
- Legality, with off = addr[1:0]:
  - byte: always legal.
  - half: legal for off in {0,1,2}.
  - word: legal for off = 0.
  - size 3: illegal.
- Write strobes:
  - byte: 4'b0001 << off.
  - half: off 0 -> 0011, off 1 -> 0110, off 2 -> 1100.
  - word: 1111.
  - Illegal: strobe 0000 and we0 = 0.
- Read extraction: lane = mem_rd_dout0 >> (8*off).
  - byte: lane[7:0].
  - half: lane[15:0].
  - Sign-extend unless unsigned; word passes through.
- Store responses: rvalid pulses with rdata = 0.
- Illegal access: no memory write, rdata = 0, err = 1 with rvalid.
- mN_rvalid and mN_err are asserted only for the requester whose id was latched.
- Requester changing or dropping req before gnt: allowed, no effect. Signals after gnt are ignored.
- Reset asserted mid-ACCESS: immediate return to IDLE, we0 deasserts, pending response discarded, no rvalid after reset release.

Test Plan:
- Store word 0xDEADBEEF via m0 at addr 0x08, then lw from 0x08 -> m0_gnt at T, mem_we0 with strb 1111 at T+1, m0_rvalid at T+2, m0_rdata = 0xDEADBEEF on the load.
- sb 0x80 at addr 0x0D, then lb 0x0D and lbu 0x0D -> strb 0010, wr_din0[7:0] = 0x80; rdata 0xFFFFFF80 then 0x00000080.
- sh 0x8001 at addr 0x12 -> strb 1100. lh 0x12 -> 0xFFFF8001, lhu -> 0x00008001. Also a half at off 1 -> strb 0110.
- m0 and m1 hold req continuously from reset -> grants alternate m0, m1, m0, m1 every 2 cycles; each rvalid goes only to its own requester.
- lw at addr 0x06 and sh at addr 0x03 -> no we0, rvalid with err = 1 and rdata = 0; prior memory contents unchanged.
- Assert reset during ACCESS of a store -> no write, no rvalid, state IDLE; first post-reset tie grants m0.
